softmax_ru: RTL and testbench
=============================

SOFTMAX_RU -- requirements
Module: softmax_ru

Interface
REQ-001 Parameter LOG2E_Q88, default 16'h0171, log2(e) constant in signed Q8.8 used by the scaling multiplier.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  pipeline advance enable; when low, every register holds.
REQ-005 valid_in  input  1  marks in_0/in_1/sel_* as a valid operation this cycle.
REQ-006 in_0  input  16  signed Q8.8 operand 0 (max value / log2-sum).
REQ-007 in_1  input  16  signed Q8.8 operand 1 (x_i / y_i).
REQ-008 sel_mux  input  1  subtraction order: 1 -> in_1 - in_0; 0 -> in_0 - in_1.
REQ-009 sel_mult  input  1  scaling: 1 -> multiply by LOG2E_Q88; 0 -> multiply by 1 (pass-through).
REQ-010 out_0  output  16  signed Q8.8 scaled difference d.
REQ-011 out_1  output  16  signed Q8.8 approximation of 2^d.
REQ-012 valid_out  output  1  out_0/out_1 hold a new result this cycle.

Function
REQ-013 Pipeline SHALL have 3 register stages: S1 subtract, S2 scale, S3 pow2; all advance only when en=1.
REQ-014 Latency SHALL be 3 enabled clock edges from the edge sampling valid_in=1 to valid_out=1; throughput one operation per enabled cycle.
REQ-015 Valid bits SHALL shift with the data; a stage's data registers load only when its incoming valid bit is 1, otherwise hold.
REQ-016 valid_out SHALL be a one-cycle pulse per accepted operation (stays high for consecutive operations); outputs hold last result after it drops.
REQ-017 S1: 17-bit signed difference per sel_mux, saturated to [0x8000, 0x7FFF].
REQ-018 S2, sel_mult=1: 32-bit signed product d*LOG2E_Q88, arithmetic shift right 8 (floor), saturated to 16 bits; sel_mult=0: d passed unchanged.
REQ-019 S3: split scaled d into integer k = d[15:8] (signed, floor) and fraction f = d[7:0]; mantissa m = 256 + f (linear 2^f ~ 1+f).
REQ-020 S3, k >= 0: out_1 = m << k, saturated to 0x7FFF when k >= 7.
REQ-021 S3, k < 0: out_1 = m >> (-k), truncating; out_1 = 0 when k <= -9.
REQ-022 out_0 and out_1 SHALL belong to the same operation and update on the same edge as valid_out.
REQ-023 sel_mux/sel_mult SHALL be sampled with valid_in and carried with the operation; per-operation mode changes take effect without bubbles.
REQ-024 valid_in with en=0 SHALL be ignored (not captured).

Reset
REQ-025 On a rising edge with rst=0: all valid bits, all stage registers, out_0, out_1 SHALL become 0, valid_out 0; takes priority over en.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; no valid_out for them after release.

Verification
REQ-027 sel_mux=1, sel_mult=1, in_0=0x0240, in_1=0x0100 -> after 3 edges valid_out=1, out_0=0xFE32, out_1=0x004C.
REQ-028 sel_mux=0, sel_mult=0, in_0=0xE125, in_1=0x2D44 -> out_0=0xB3E1, out_1=0x0000 (k<=-9 underflow).
REQ-029 in_0=in_1=0x0100, sel_mult=1 -> out_0=0x0000, out_1=0x0100; sel_mux=0, sel_mult=0, in_0=0x0100, in_1=0 -> out_0=0x0100, out_1=0x0200.
REQ-030 Saturation: sel_mux=0, sel_mult=0, in_0=0x0800, in_1=0 -> out_1=0x7FFF; sel_mux=1, in_1=0x7FFF, in_0=0x8000 -> out_0=0x7FFF.
REQ-031 Back-to-back valid_in on 3 consecutive cycles with mixed sel -> 3 consecutive valid_out cycles, results in order; en=0 for 2 cycles mid-stream -> outputs and valid_out frozen, latency stretched by 2.
REQ-032 rst=0 for one edge while 2 operations in flight -> outputs 0, valid_out never asserted for them.

Source files
------------

// File: rtl/softmax_ru_if.sv
// Operand/result bundle for the softmax range-reduction unit.
// Latency: n/a (wiring only).
// Backpressure: none; the en signal stalls the whole pipeline.
interface softmax_ru_if;
  logic        en;
  logic        valid_in;
  logic [15:0] in_0;
  logic [15:0] in_1;
  logic        sel_mux;
  logic        sel_mult;
  logic [15:0] out_0;
  logic [15:0] out_1;
  logic        valid_out;

  // Producer side: drives operands, observes results
  modport master (
    output en, valid_in, in_0, in_1, sel_mux, sel_mult,
    input  out_0, out_1, valid_out
  );

  // Pipeline side: consumes operands, drives results
  modport slave (
    input  en, valid_in, in_0, in_1, sel_mux, sel_mult,
    output out_0, out_1, valid_out
  );
endinterface

// File: rtl/softmax_ru.sv
// Softmax helper: saturating subtract, optional log2(e) scaling, then linear 2^d approximation.
// Latency: 3 enabled clock edges, one operation per enabled cycle.
// Backpressure: none; en=0 freezes every register (valid_in ignored while stalled).
module softmax_ru #(
  parameter logic [15:0] LOG2E_Q88 = 16'h0171
) (
  input logic         clk,
  input logic         rst,
  softmax_ru_if.slave io
);

  // Stage 1 state: difference and the scaling mode that travels with it
  logic        s1_vld_q, s1_vld_d;
  logic [15:0] s1_d_q, s1_d_d;
  logic        s1_mult_q, s1_mult_d;
  // Stage 2 state: scaled difference
  logic        s2_vld_q, s2_vld_d;
  logic [15:0] s2_d_q, s2_d_d;
  // Stage 3 state: visible results
  logic        out_vld_q, out_vld_d;
  logic [15:0] out_0_q, out_0_d;
  logic [15:0] out_1_q, out_1_d;

  logic [16:0] diff17;
  logic [15:0] diff_sat;
  logic signed [31:0] prod;
  logic signed [31:0] prod_sh;
  logic [15:0] scaled;
  logic [7:0]  k;
  logic [7:0]  k_neg;
  logic [15:0] mant;
  logic [15:0] pow2;

  // S1 datapath: 17-bit difference in the selected order, clamped to 16 bits
  always_comb begin
    diff17   = 17'd0;
    diff_sat = 16'd0;
    if (io.sel_mux) begin
      diff17 = {io.in_1[15], io.in_1} - {io.in_0[15], io.in_0};
    end else begin
      diff17 = {io.in_0[15], io.in_0} - {io.in_1[15], io.in_1};
    end
    if (diff17[16] != diff17[15]) begin
      diff_sat = diff17[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      diff_sat = diff17[15:0];
    end
  end

  // S2 datapath: Q8.8 product floored back to Q8.8, clamped; bypassed when unscaled
  always_comb begin
    prod    = $signed(s1_d_q) * $signed(LOG2E_Q88);
    prod_sh = prod >>> 8;
    scaled  = s1_d_q;
    if (s1_mult_q) begin
      if (prod_sh[31:15] == 17'h00000 || prod_sh[31:15] == 17'h1FFFF) begin
        scaled = prod_sh[15:0];
      end else begin
        scaled = prod_sh[31] ? 16'h8000 : 16'h7FFF;
      end
    end
  end

  // S3 datapath: 2^k * (1 + f) with overflow clamp and underflow to zero
  always_comb begin
    k     = s2_d_q[15:8];
    k_neg = ~k + 8'd1;
    mant  = {7'd0, 1'b1, s2_d_q[7:0]};
    pow2  = 16'd0;
    if (!k[7]) begin
      if (k >= 8'd7) begin
        pow2 = 16'h7FFF;
      end else begin
        pow2 = mant << k[2:0];
      end
    end else begin
      if (k_neg > 8'd8) begin
        pow2 = 16'd0;
      end else begin
        pow2 = mant >> k_neg[3:0];
      end
    end
  end

  // Next-state: valids shift on en, data loads only behind an incoming valid
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d_d    = s1_d_q;
    s1_mult_d = s1_mult_q;
    s2_vld_d  = s2_vld_q;
    s2_d_d    = s2_d_q;
    out_vld_d = out_vld_q;
    out_0_d   = out_0_q;
    out_1_d   = out_1_q;
    if (io.en) begin
      s1_vld_d  = io.valid_in;
      s2_vld_d  = s1_vld_q;
      out_vld_d = s2_vld_q;
      if (io.valid_in) begin
        s1_d_d    = diff_sat;
        s1_mult_d = io.sel_mult;
      end
      if (s1_vld_q) begin
        s2_d_d = scaled;
      end
      if (s2_vld_q) begin
        out_0_d = s2_d_q;
        out_1_d = pow2;
      end
    end
  end

  // Pipeline registers with synchronous active-low clear taking priority over en
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_d_q    <= 16'd0;
      s1_mult_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_d_q    <= 16'd0;
      out_vld_q <= 1'b0;
      out_0_q   <= 16'd0;
      out_1_q   <= 16'd0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_d_q    <= s1_d_d;
      s1_mult_q <= s1_mult_d;
      s2_vld_q  <= s2_vld_d;
      s2_d_q    <= s2_d_d;
      out_vld_q <= out_vld_d;
      out_0_q   <= out_0_d;
      out_1_q   <= out_1_d;
    end
  end

  assign io.out_0     = out_0_q;
  assign io.out_1     = out_1_q;
  assign io.valid_out = out_vld_q;

endmodule

// File: tb/tb_softmax_ru.sv
// Directed bench for softmax_ru with hand-computed expectations.
// Latency: checks the 3-edge result timing and en stalls.
// Backpressure: exercises en=0 freeze and reset flush.
module tb_softmax_ru;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  softmax_ru_if io ();

  softmax_ru #(.LOG2E_Q88(16'h0171)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, return just after the rising edge
  task automatic step(input logic en, input logic vld, input logic [15:0] a,
                      input logic [15:0] b, input logic smux, input logic smult);
    @(negedge clk);
    io.en       = en;
    io.valid_in = vld;
    io.in_0     = a;
    io.in_1     = b;
    io.sel_mux  = smux;
    io.sel_mult = smult;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'h1234, 16'h4321, 1'b1, 1'b1);
  endtask

  // Single isolated operation: check latency, result, then the drop and hold
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic smux, input logic smult,
                         input logic [15:0] e0, input logic [15:0] e1);
    step(1'b1, 1'b1, a, b, smux, smult);
    chk({tag, ".vld_e1"}, 32'(io.valid_out), 32'd0);
    idle();
    chk({tag, ".vld_e2"}, 32'(io.valid_out), 32'd0);
    idle();
    chk({tag, ".vld_e3"}, 32'(io.valid_out), 32'd1);
    chk({tag, ".out_0"}, 32'(io.out_0), 32'(e0));
    chk({tag, ".out_1"}, 32'(io.out_1), 32'(e1));
    idle();
    chk({tag, ".vld_drop"}, 32'(io.valid_out), 32'd0);
    chk({tag, ".out_1_hold"}, 32'(io.out_1), 32'(e1));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    io.en = 1'b0; io.valid_in = 1'b0; io.in_0 = 16'd0; io.in_1 = 16'd0;
    io.sel_mux = 1'b0; io.sel_mult = 1'b0;

    // Reset state
    step(1'b1, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
    chk("rst.out_0", 32'(io.out_0), 32'd0);
    chk("rst.out_1", 32'(io.out_1), 32'd0);
    chk("rst.vld", 32'(io.valid_out), 32'd0);
    rst = 1'b1;
    idle(); idle(); idle();
    chk("rst.no_leak", 32'(io.valid_out), 32'd0);

    // Single operations
    run_one("scale_neg",  16'h0240, 16'h0100, 1'b1, 1'b1, 16'hFE32, 16'h004C);
    run_one("underflow",  16'hE125, 16'h2D44, 1'b0, 1'b0, 16'hB3E1, 16'h0000);
    run_one("zero_diff",  16'h0100, 16'h0100, 1'b1, 1'b1, 16'h0000, 16'h0100);
    run_one("k_one",      16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0100, 16'h0200);
    run_one("pow_sat",    16'h0800, 16'h0000, 1'b0, 1'b0, 16'h0800, 16'h7FFF);
    run_one("sub_sat_hi", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
    run_one("sub_sat_lo", 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h0000);
    run_one("scale_pos",  16'h0180, 16'h0000, 1'b0, 1'b1, 16'h0229, 16'h04A4);
    run_one("k_six",      16'h06FF, 16'h0000, 1'b0, 1'b0, 16'h06FF, 16'h7FC0);
    run_one("k_seven",    16'h0700, 16'h0000, 1'b0, 1'b0, 16'h0700, 16'h7FFF);
    run_one("k_neg8",     16'h0000, 16'h0800, 1'b0, 1'b0, 16'hF800, 16'h0001);
    run_one("k_neg9",     16'h0000, 16'h0900, 1'b0, 1'b0, 16'hF700, 16'h0000);

    // Back-to-back with mixed modes
    step(1'b1, 1'b1, 16'h0240, 16'h0100, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    chk("b2b.a.vld", 32'(io.valid_out), 32'd1);
    chk("b2b.a.out_0", 32'(io.out_0), 32'hFE32);
    chk("b2b.a.out_1", 32'(io.out_1), 32'h004C);
    idle();
    chk("b2b.b.vld", 32'(io.valid_out), 32'd1);
    chk("b2b.b.out_0", 32'(io.out_0), 32'h0100);
    chk("b2b.b.out_1", 32'(io.out_1), 32'h0200);
    idle();
    chk("b2b.c.vld", 32'(io.valid_out), 32'd1);
    chk("b2b.c.out_0", 32'(io.out_0), 32'hF800);
    chk("b2b.c.out_1", 32'(io.out_1), 32'h0001);
    idle();
    chk("b2b.end", 32'(io.valid_out), 32'd0);

    // Stall: en low for two edges, a valid_in during the stall must be dropped
    step(1'b1, 1'b1, 16'h0240, 16'h0100, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0000, 16'h0800, 1'b0, 1'b0);
    chk("stall.a.vld", 32'(io.valid_out), 32'd1);
    step(1'b0, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0);
    chk("stall.hold1.vld", 32'(io.valid_out), 32'd1);
    chk("stall.hold1.out_0", 32'(io.out_0), 32'hFE32);
    step(1'b0, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0);
    chk("stall.hold2.vld", 32'(io.valid_out), 32'd1);
    chk("stall.hold2.out_1", 32'(io.out_1), 32'h004C);
    idle();
    chk("stall.b.out_0", 32'(io.out_0), 32'h0100);
    chk("stall.b.out_1", 32'(io.out_1), 32'h0200);
    idle();
    chk("stall.c.vld", 32'(io.valid_out), 32'd1);
    chk("stall.c.out_0", 32'(io.out_0), 32'hF800);
    idle();
    chk("stall.end1", 32'(io.valid_out), 32'd0);
    idle();
    chk("stall.end2", 32'(io.valid_out), 32'd0);
    chk("stall.no_ghost", 32'(io.out_0), 32'hF800);

    // Reset with two operations in flight
    run_one("pre_rst", 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0100, 16'h0200);
    step(1'b1, 1'b1, 16'h0240, 16'h0100, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    chk("flush.out_0", 32'(io.out_0), 32'd0);
    chk("flush.out_1", 32'(io.out_1), 32'd0);
    chk("flush.vld", 32'(io.valid_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("flush.quiet%0d", i), 32'(io.valid_out), 32'd0);
    end
    chk("flush.out_0_stay", 32'(io.out_0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
